rom_loader: RTL and testbench
=============================

# rom_loader

Streaming loader that fills the 16 KB game ROM through its write port (`we_b`, `din_b`, `addr_b`) before the MSX core runs. It accepts a byte stream with a valid/ready handshake, typically from the SPI/OSD receiver. It writes the bytes to consecutive ROM addresses and reports completion, overflow or a bad cartridge image. While it holds `loading` high, the CPU is kept in reset.

## Interface
- `ADDR_WIDTH`, 14: ROM address bits. Capacity is 2^ADDR_WIDTH bytes.
- `BASE_ADDR`, 16'h0000: value driven on `addr_b` for the first byte.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse that begins a load.
- `abort` input 1: cancels a load in progress.
- `in_valid` input 1: stream byte is valid.
- `in_data` input 8: stream byte.
- `in_last` input 1: qualifies the final byte of the image.
- `in_ready` output 1: the loader accepts the byte this cycle.
- `we_b` output 1: ROM write strobe, one cycle per byte.
- `din_b` output 8: ROM write data.
- `addr_b` output 16: ROM write address.
- `loading` output 1: high in LOAD. Holds the CPU in reset.
- `done` output 1: sticky. The image loaded successfully.
- `error` output 1: sticky. Overflow or bad signature.
- `byte_count` output ADDR_WIDTH+1: number of bytes written in the current or last load.

## Operation
- States: IDLE, LOAD, DONE, ERR.
- IDLE:
  - `in_ready`=0.
  - `start` moves to LOAD and clears `byte_count`, `done` and `error`.
- LOAD:
  - `in_ready`=1.
  - An accept is `in_valid & in_ready`.
  - Each accept registers `din_b`=`in_data` and `addr_b`=`BASE_ADDR`+`byte_count` (zero-extended to 16 bits).
  - Each accept pulses `we_b` and increments `byte_count`.
- Accepting a byte with `in_last`=1 moves to DONE, after that byte's write has been issued.
- Overflow: a byte accepted when `byte_count` == 2^ADDR_WIDTH moves to ERR. That byte is not written, and `byte_count` is not incremented.
- `in_last` on the byte at index 2^ADDR_WIDTH-1 (the final slot) is legal and moves to DONE.
- `abort` in LOAD moves to IDLE.
  - The write for a byte accepted in the same cycle is suppressed.
  - `done` and `error` stay 0.
- DONE and ERR:
  - `in_ready`=0.
  - `start` begins a new load, as from IDLE.
  - `abort` moves to IDLE and clears `done` and `error`.
- `start` while in LOAD is ignored.
- If `start` and `abort` arrive in the same cycle, `abort` wins.
- Arithmetic: `byte_count` saturates at 2^ADDR_WIDTH. `addr_b` uses unsigned 16-bit addition, and wraps at 16'hFFFF.

## Timing
- Reset values, all outputs: `in_ready`=0, `we_b`=0, `din_b`=8'h00, `addr_b`=16'h0000, `loading`=0, `done`=0, `error`=0, `byte_count`=0. State is IDLE.
- Reset takes effect at the next clock edge. A reset in the middle of a load discards the write that is pending.
- `in_ready` is a registered function of state and is high in the first cycle of LOAD.
- Write latency: a byte accepted at edge N gives `we_b`=1 with its `din_b` and `addr_b` during cycle N+1.
  - `we_b` is high for exactly one cycle per byte.
  - Back-to-back accepts give one write per cycle.
- `byte_count` updates at the same edge as `we_b` asserts.
- `done` and `error` rise on the edge after the terminating accept. `loading` falls on that same edge.
- `done` and `error` are never high together.

## Configuration
- `ROM_LOADER_SIG_CHECK_EN`
  - Defined: bytes 0 and 1 of the image must be 8'h41 and 8'h42 ("AB", the MSX cartridge header).
    - A mismatch on either byte moves to ERR on the edge after that byte is accepted.
    - The mismatching byte is still written; no further bytes are written.
    - An image whose `in_last` falls on byte 0 is an error.
  - Undefined: no content check. Any image of 1 to 2^ADDR_WIDTH bytes reaches DONE.

## Test plan
- Normal load:
  - Stimulus: `start`, then 16 bytes 41,42,00..0D, with `in_valid` held high and `in_last` on the 16th byte.
  - Response: 16 `we_b` pulses at `addr_b` 0..15 with matching data; `done`=1; `byte_count`=16; `loading` low the cycle after the last accept.
- Full capacity:
  - Stimulus: 16384 bytes, with `in_last` on the last byte.
  - Response: the last write goes to 16'h3FFF; `done`=1; `byte_count`=16384.
- Overflow:
  - Stimulus: 16385 bytes with no `in_last`.
  - Response: exactly 16384 writes; `error`=1; `in_ready`=0 afterwards.
- Handshake gaps and abort:
  - Stimulus: toggle `in_valid` 1-0-1; then assert `abort` together with the 5th accept.
  - Response: no write for the gap cycles; 4 writes in total; state returns to IDLE with `done`=`error`=0.
- Signature (macro defined):
  - Stimulus: first bytes 41,43.
  - Response: 2 writes, then `error`=1.
  - With the macro undefined, the same image reaches `done`.
- Reset mid-load:
  - Stimulus: assert `reset` on the edge a byte is accepted.
  - Response: no `we_b` pulse follows; all outputs are at their reset values; a later `start` loads from `addr_b`=`BASE_ADDR`.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: streams a byte image into the game ROM write port and holds
// the CPU in reset (loading) while the image is being written.
//
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   start, abort         - begin a load / cancel or acknowledge a load
//   in_valid, in_data,
//   in_last, in_ready    - byte stream with valid/ready handshake
//   we_b, din_b, addr_b  - ROM write port (one-cycle strobe per byte)
//   loading, done, error - status (done/error are sticky)
//   byte_count           - bytes written in the current or last load
//
// Optional build macro: ROM_LOADER_SIG_CHECK_EN enables the "AB" cartridge
// header check on bytes 0 and 1.

module rom_loader #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  we_b,
  output logic [7:0]            din_b,
  output logic [15:0]           addr_b,
  output logic                  loading,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   byte_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e              state_q, state_d;
  logic                ld_q, ld_d;
  logic                we_q, we_d;
  logic [7:0]          din_q, din_d;
  logic [15:0]         addr_q, addr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;

  logic accept;
  logic full;
  logic sig_bad;

  // ld_q mirrors "next state is LOAD", so in_ready is already high in
  // the first LOAD cycle without a combinational path from state_q.
  assign accept = in_valid & ld_q;
  assign full   = (cnt_q == CAP);

`ifdef ROM_LOADER_SIG_CHECK_EN
  // Header must read "AB"; a one-byte image can never carry it.
  always_comb begin
    sig_bad = 1'b0;
    if (cnt_q == '0) begin
      sig_bad = (in_data != 8'h41) | in_last;
    end else if (cnt_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
      sig_bad = (in_data != 8'h42);
    end
  end
`else
  assign sig_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    din_d   = din_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_LOAD: begin
        if (abort) begin
          // Any byte accepted this cycle is dropped.
          state_d = S_IDLE;
        end else if (accept) begin
          if (full) begin
            // Overflow byte is neither written nor counted.
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            we_d   = 1'b1;
            din_d  = in_data;
            addr_d = BASE_ADDR + 16'(cnt_q);
            cnt_d  = cnt_q + 1'b1;
            if (sig_bad) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else if (in_last) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_IDLE,
      S_DONE,
      S_ERR: begin
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ld_d = (state_d == S_LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_q   <= 1'b0;
      we_q   <= 1'b0;
      din_q  <= 8'h00;
      addr_q <= 16'h0000;
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ld_q   <= ld_d;
      we_q   <= we_d;
      din_q  <= din_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign in_ready   = ld_q;
  assign loading    = ld_q;
  assign we_b       = we_q;
  assign din_b      = din_q;
  assign addr_b     = addr_q;
  assign done       = done_q;
  assign error      = err_q;
  assign byte_count = cnt_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized and directed stimulus for rom_loader, checked
// every cycle against a transaction-level model plus literal expectations.

module tb_rom_loader;

  localparam int          AW   = 14;
  localparam int          CAP  = 1 << AW;
  localparam logic [15:0] BASE = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, start, abort, in_valid, in_last;
  logic [7:0]  in_data;
  logic        in_ready, we_b, loading, done, error;
  logic [7:0]  din_b;
  logic [15:0] addr_b;
  logic [AW:0] byte_count;

  always #5 clk = ~clk;

  rom_loader #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .we_b      (we_b),
    .din_b     (din_b),
    .addr_b    (addr_b),
    .loading   (loading),
    .done      (done),
    .error     (error),
    .byte_count(byte_count)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;
  int cyc    = 0;
  int wr_total = 0;
  logic [15:0] last_addr = 16'h0;
  logic [7:0]  last_din  = 8'h0;

  // Model: only "is a load running", the running byte count and the
  // sticky flags; the write port is whatever the last accepted byte was.
  bit          m_ld, m_we, m_done, m_err;
  logic [7:0]  m_din;
  logic [15:0] m_addr;
  int          m_cnt;

  function automatic bit sig_fail(int idx, logic [7:0] d, logic last);
`ifdef ROM_LOADER_SIG_CHECK_EN
    if (idx == 0) return (d != 8'h41) || last;
    if (idx == 1) return (d != 8'h42);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    m_we = 1'b0;
    if (reset) begin
      m_ld = 0; m_done = 0; m_err = 0;
      m_din = 8'h00; m_addr = 16'h0000; m_cnt = 0;
    end else if (m_ld) begin
      if (abort) begin
        m_ld = 0;
      end else if (in_valid) begin
        if (m_cnt == CAP) begin
          m_ld = 0; m_err = 1;
        end else begin
          m_we   = 1;
          m_din  = in_data;
          m_addr = 16'((int'(BASE) + m_cnt) % 65536);
          if (sig_fail(m_cnt, in_data, in_last)) begin
            m_ld = 0; m_err = 1;
          end else if (in_last) begin
            m_ld = 0; m_done = 1;
          end
          m_cnt++;
        end
      end
    end else if (abort) begin
      m_done = 0; m_err = 0;
    end else if (start) begin
      m_ld = 1; m_cnt = 0; m_done = 0; m_err = 0;
    end
  end

  task automatic cmp_cycle();
    n_chk++;
    if (in_ready !== m_ld || loading !== m_ld || we_b !== m_we ||
        din_b !== m_din || addr_b !== m_addr ||
        byte_count !== (AW+1)'(m_cnt) || done !== m_done ||
        error !== m_err || (done & error) !== 1'b0) begin
      n_fail++;
      $display("FAIL cycle %0d model: got rdy=%b we=%b din=%h addr=%h ld=%b done=%b err=%b cnt=%0d, want rdy=%b we=%b din=%h addr=%h ld=%b done=%b err=%b cnt=%0d",
               cyc, in_ready, we_b, din_b, addr_b, loading, done, error,
               byte_count, m_ld, m_we, m_din, m_addr, m_ld, m_done, m_err,
               m_cnt);
    end
    if (we_b === 1'b1) begin
      wr_total++;
      last_addr = addr_b;
      last_din  = din_b;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) cmp_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic send(logic [7:0] d, logic last);
    in_valid = 1; in_data = d; in_last = last; tick();
  endtask

  task automatic idle_in();
    in_valid = 0; in_last = 0; in_data = 8'h00; start = 0; abort = 0;
  endtask

  int base_wr;

  initial begin
    reset = 1;
    idle_in();
    tick(); tick();
    chk_en = 1;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_we",    32'(we_b), 0);
    chk("rst_addr",  32'(addr_b), 0);
    chk("rst_cnt",   32'(byte_count), 0);
    chk("rst_flags", {29'd0, loading, done, error}, 0);
    reset = 0;
    tick();

    // Normal 16-byte load.
    base_wr = wr_total;
    do_start();
    chk("start_ready", 32'(in_ready), 1);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      d = (i == 0) ? 8'h41 : (i == 1) ? 8'h42 : 8'(i - 2);
      send(d, i == 15);
    end
    idle_in();
    chk("norm_done", 32'(done), 1);
    chk("norm_loading", 32'(loading), 0);
    chk("norm_cnt", 32'(byte_count), 16);
    chk("norm_last_addr", 32'(addr_b), 15);
    chk("norm_last_din", 32'(din_b), 32'h0D);
    tick();
    chk("norm_writes", 32'(wr_total - base_wr), 16);

    // Full capacity.
    base_wr = wr_total;
    do_start();
    for (int i = 0; i < CAP; i++) begin
      logic [7:0] d;
      d = (i == 0) ? 8'h41 : (i == 1) ? 8'h42 : 8'($urandom);
      send(d, i == CAP - 1);
    end
    idle_in();
    tick();
    chk("full_done", 32'(done), 1);
    chk("full_cnt", 32'(byte_count), CAP);
    chk("full_last_addr", 32'(last_addr), 32'h3FFF);
    chk("full_writes", 32'(wr_total - base_wr), CAP);

    // Overflow.
    base_wr = wr_total;
    do_start();
    for (int i = 0; i <= CAP; i++) begin
      logic [7:0] d;
      d = (i == 0) ? 8'h41 : (i == 1) ? 8'h42 : 8'($urandom);
      send(d, 1'b0);
    end
    idle_in();
    chk("ovf_error", 32'(error), 1);
    chk("ovf_done", 32'(done), 0);
    chk("ovf_ready", 32'(in_ready), 0);
    chk("ovf_cnt", 32'(byte_count), CAP);
    tick();
    chk("ovf_writes", 32'(wr_total - base_wr), CAP);

    // Gaps then abort on the 5th accept.
    base_wr = wr_total;
    do_start();
    send(8'h41, 0);
    in_valid = 0; tick();
    send(8'h42, 0);
    in_valid = 0; tick();
    send(8'h10, 0);
    send(8'h11, 0);
    abort = 1;
    send(8'h12, 0);
    idle_in();
    chk("abort_ld", 32'(loading), 0);
    chk("abort_flags", {30'd0, done, error}, 0);
    chk("abort_we", 32'(we_b), 0);
    chk("abort_cnt", 32'(byte_count), 4);
    tick();
    chk("abort_writes", 32'(wr_total - base_wr), 4);

    // Signature image 41,43,...
    base_wr = wr_total;
    do_start();
    send(8'h41, 0);
    send(8'h43, 0);
    send(8'h20, 0);
    send(8'h21, 1);
    idle_in();
    tick();
`ifdef ROM_LOADER_SIG_CHECK_EN
    chk("sig_error", 32'(error), 1);
    chk("sig_writes", 32'(wr_total - base_wr), 2);
`else
    chk("sig_done", 32'(done), 1);
    chk("sig_writes", 32'(wr_total - base_wr), 4);
`endif

    // Reset on the edge a byte is accepted.
    do_start();
    send(8'h41, 0);
    send(8'h42, 0);
    send(8'h55, 0);
    reset = 1;
    send(8'h66, 0);
    idle_in();
    chk("mrst_we", 32'(we_b), 0);
    chk("mrst_addr", 32'(addr_b), 0);
    chk("mrst_din", 32'(din_b), 0);
    chk("mrst_cnt", 32'(byte_count), 0);
    chk("mrst_flags", {29'd0, loading, done, error}, 0);
    reset = 0;
    tick();
    do_start();
    send(8'h41, 0);
    idle_in();
    chk("mrst_re_we", 32'(we_b), 1);
    chk("mrst_re_addr", 32'(addr_b), 32'(BASE));
    abort = 1; tick(); abort = 0;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 499) == 0);
      start    = ($urandom_range(0, 19) == 0);
      abort    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 9) < 6);
      in_last  = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0: in_data = 8'h41;
        1: in_data = 8'h42;
        default: in_data = 8'($urandom);
      endcase
      tick();
    end
    idle_in();
    reset = 0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
